// File: rtl/conv_pkg.sv
// Shared definitions for the conv-stage tile loader: default geometry,
// write FSM state encoding and the signed pixel type.
package conv_pkg;

  localparam int CONV_DW   = 8;
  localparam int CONV_N    = 8;
  localparam int CONV_IDXW = $clog2(CONV_N * CONV_N);

  typedef logic signed [CONV_DW-1:0] pixel_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_WAIT = 2'd2
  } wr_state_t;

endpackage

// File: rtl/conv_tile_bank.sv
// One N x N pixel register bank: single-pixel write port, whole tile
// presented as a flat word with pixel i at bits [i*DW +: DW].
module conv_tile_bank #(
  parameter int DW   = 8,
  parameter int N    = 8,
  parameter int IDXW = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_we,
  input  logic [IDXW-1:0]     i_idx,
  input  logic [DW-1:0]       i_data,
  output logic [N*N*DW-1:0]   o_flat
);

  logic [DW-1:0] r_mem [N*N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N*N; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < N*N; g++) begin : g_flat
    assign o_flat[g*DW +: DW] = r_mem[g];
  end

endmodule

// File: rtl/conv_frame_loader.sv
// Raster pixel stream -> N x N tiles through a ping-pong pair of banks.
// Optional drop/abort counters are built when FRAME_LOADER_STATS_EN is defined.
//
// state   | meaning
// WR_IDLE | waiting for a pixel flagged pix_sof; other pixels are dropped
// WR_FILL | writing pixels of the current tile into the write bank
// WR_WAIT | both banks hold full tiles; input stalled until one drains
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int DW   = CONV_DW,
  parameter int N    = CONV_N,
  parameter int IDXW = CONV_IDXW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               pix_sof,
  input  logic [DW-1:0]      pix_data,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [N*N*DW-1:0]  frame_data,
  output logic               busy
`ifdef FRAME_LOADER_STATS_EN
  ,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        abort_cnt
`endif
);

  localparam int              NN   = N * N;
  localparam logic [IDXW-1:0] LAST = IDXW'(NN - 1);

  wr_state_t       r_state, w_state_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic            r_wbank, w_wbank_nxt;
  logic            r_rbank, w_rbank_nxt;
  logic [1:0]      r_full;
  logic            r_frame_valid;
  logic            r_pix_ready;

  logic            w_pix_xfer;
  logic            w_frm_xfer;
  logic            w_we;
  logic [IDXW-1:0] w_widx;
  logic            w_complete;
  logic [1:0]      w_full_after_rd;
  logic [1:0]      w_full_nxt;
  logic [NN*DW-1:0] w_flat0, w_flat1;

  assign w_pix_xfer = pix_valid && r_pix_ready;
  assign w_frm_xfer = r_frame_valid && frame_ready;

  // Read-side release is computed separately so the FSM can see a bank
  // freed in this very cycle without a combinational loop through w_complete.
  assign w_full_after_rd = r_full & ~(w_frm_xfer ? (2'b01 << r_rbank) : 2'b00);
  assign w_full_nxt      = w_full_after_rd | (w_complete ? (2'b01 << r_wbank) : 2'b00);
  assign w_rbank_nxt     = w_frm_xfer ? ~r_rbank : r_rbank;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_wbank_nxt = r_wbank;
    w_we        = 1'b0;
    w_widx      = r_ptr;
    w_complete  = 1'b0;
    case (r_state)
      WR_IDLE: begin
        if (w_pix_xfer && pix_sof) begin
          w_we        = 1'b1;
          w_widx      = '0;
          w_ptr_nxt   = IDXW'(1);
          w_state_nxt = WR_FILL;
        end
      end
      WR_FILL: begin
        if (w_pix_xfer) begin
          w_we = 1'b1;
          if (pix_sof) begin
            w_widx    = '0;
            w_ptr_nxt = IDXW'(1);
          end else if (r_ptr == LAST) begin
            w_complete  = 1'b1;
            w_ptr_nxt   = '0;
            w_wbank_nxt = ~r_wbank;
            w_state_nxt = w_full_after_rd[~r_wbank] ? WR_WAIT : WR_IDLE;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      WR_WAIT: begin
        if (!w_full_after_rd[r_wbank]) w_state_nxt = WR_IDLE;
      end
      default: w_state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WR_IDLE;
      r_ptr         <= '0;
      r_wbank       <= 1'b0;
      r_rbank       <= 1'b0;
      r_full        <= 2'b00;
      r_frame_valid <= 1'b0;
      r_pix_ready   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_wbank       <= w_wbank_nxt;
      r_rbank       <= w_rbank_nxt;
      r_full        <= w_full_nxt;
      r_frame_valid <= w_full_nxt[w_rbank_nxt];
      r_pix_ready   <= (w_state_nxt != WR_WAIT);
    end
  end

  conv_tile_bank #(.DW(DW), .N(N), .IDXW(IDXW)) u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we && !r_wbank),
    .i_idx  (w_widx),
    .i_data (pix_data),
    .o_flat (w_flat0)
  );

  conv_tile_bank #(.DW(DW), .N(N), .IDXW(IDXW)) u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we && r_wbank),
    .i_idx  (w_widx),
    .i_data (pix_data),
    .o_flat (w_flat1)
  );

  // A held tile cannot be overwritten: its bank is FULL, so the writer is
  // either on the other bank or parked in WR_WAIT.
  assign frame_data  = r_rbank ? w_flat1 : w_flat0;
  assign frame_valid = r_frame_valid;
  assign pix_ready   = r_pix_ready;
  assign busy        = (r_state == WR_FILL);

`ifdef FRAME_LOADER_STATS_EN
  logic        w_drop, w_abort;
  logic [15:0] r_drop_cnt, r_abort_cnt;

  assign w_drop  = w_pix_xfer && (r_state == WR_IDLE) && !pix_sof;
  assign w_abort = w_pix_xfer && (r_state == WR_FILL) && pix_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != 16'hFFFF))   r_drop_cnt  <= r_drop_cnt + 16'd1;
      if (w_abort && (r_abort_cnt != 16'hFFFF)) r_abort_cnt <= r_abort_cnt + 16'd1;
    end
  end

  assign drop_cnt  = r_drop_cnt;
  assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: reset, single/back-to-back tiles,
// simultaneous complete+release, signed data, sof abort, drops, reset mid-fill.
module tb_conv_frame_loader;
  import conv_pkg::*;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int W  = N * N * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic [DW-1:0] pix_data;
  logic         frame_valid;
  logic         frame_ready;
  logic [W-1:0] frame_data;
  logic         busy;
`ifdef FRAME_LOADER_STATS_EN
  logic [15:0]  drop_cnt;
  logic [15:0]  abort_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .pix_data    (pix_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .busy        (busy)
`ifdef FRAME_LOADER_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .abort_cnt   (abort_cnt)
`endif
  );

  function automatic logic [W-1:0] tile_img(input logic [7:0] base);
    logic [W-1:0] img;
    img = '0;
    for (int i = 0; i < N*N; i++) img[i*DW +: DW] = base + 8'(i);
    return img;
  endfunction

  // All stimulus and sampling happens 1 time unit after a rising edge.
  task automatic push(input logic [7:0] d, input logic sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic stream_tile(input logic [7:0] base);
    for (int i = 0; i < N*N; i++) push(base + 8'(i), i == 0);
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if (pix_ready !== 1'b0) begin bad++; $display("FAIL reset_pix_ready got=%b want=0", pix_ready); end
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b want=0", frame_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (frame_data !== '0) begin bad++; $display("FAIL reset_frame_data got=%h want=0", frame_data); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pix_ready !== 1'b1) begin bad++; $display("FAIL release_pix_ready got=%b want=1", pix_ready); end
  endtask

  task automatic test_single_tile();
    logic ready_dropped;
    ready_dropped = 1'b0;
    for (int i = 0; i < N*N - 1; i++) begin
      push(8'(i), i == 0);
      if (pix_ready !== 1'b1) ready_dropped = 1'b1;
    end
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b want=0", frame_valid); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    push(8'h3F, 1'b0);
    if (pix_ready !== 1'b1) ready_dropped = 1'b1;
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", frame_valid); end
    total++;
    if (frame_data[7:0] !== 8'h00) begin bad++; $display("FAIL single_px0 got=%h want=00", frame_data[7:0]); end
    total++;
    if (frame_data[511:504] !== 8'h3F) begin bad++; $display("FAIL single_px63 got=%h want=3f", frame_data[511:504]); end
    total++;
    if (frame_data !== tile_img(8'h00)) begin bad++; $display("FAIL single_tile got=%h want=%h", frame_data, tile_img(8'h00)); end
    total++;
    if (ready_dropped !== 1'b0) begin bad++; $display("FAIL single_pix_ready got=dropped want=steady"); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", busy); end
    pulse_ready();
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b want=0", frame_valid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    stream_tile(8'h10);
    stream_tile(8'h50);
    total++;
    if (pix_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b want=0", pix_ready); end
    total++;
    if (frame_data !== tile_img(8'h10)) begin bad++; $display("FAIL b2b_tile1 got=%h want=%h", frame_data, tile_img(8'h10)); end
    // Hold: tile must stay stable while stalled.
    repeat (3) @(posedge clk); #1;
    total++;
    if (frame_valid !== 1'b1 || frame_data !== tile_img(8'h10)) begin
      bad++; $display("FAIL b2b_hold got=%b/%h want=1/%h", frame_valid, frame_data, tile_img(8'h10));
    end
    pulse_ready();
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_tile2_valid got=%b want=1", frame_valid); end
    total++;
    if (frame_data !== tile_img(8'h50)) begin bad++; $display("FAIL b2b_tile2 got=%h want=%h", frame_data, tile_img(8'h50)); end
    total++;
    if (pix_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume got=%b want=1", pix_ready); end
    stream_tile(8'h90);
    total++;
    if (pix_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall2 got=%b want=0", pix_ready); end
    pulse_ready();
    total++;
    if (frame_data !== tile_img(8'h90)) begin bad++; $display("FAIL b2b_tile3 got=%h want=%h", frame_data, tile_img(8'h90)); end
    // Tile 4 completes into bank 1 in the same cycle tile 3 is released.
    for (int i = 0; i < N*N - 1; i++) push(8'hC0 + 8'(i), i == 0);
    frame_ready = 1'b1;
    push(8'hC0 + 8'(N*N - 1), 1'b0);
    frame_ready = 1'b0;
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%b want=1", frame_valid); end
    total++;
    if (frame_data !== tile_img(8'hC0)) begin bad++; $display("FAIL simul_tile got=%h want=%h", frame_data, tile_img(8'hC0)); end
    total++;
    if (pix_ready !== 1'b1) begin bad++; $display("FAIL simul_no_wait got=%b want=1", pix_ready); end
  endtask

  task automatic test_negative();
    logic [W-1:0] exp_img;
    apply_reset();
    exp_img = tile_img(8'h00);
    exp_img[15:8]    = 8'hFF;
    exp_img[511:504] = 8'h80;
    for (int i = 0; i < N*N; i++) push(exp_img[i*DW +: DW], i == 0);
    total++;
    if (frame_data[511:504] !== 8'h80) begin bad++; $display("FAIL neg_px77 got=%h want=80", frame_data[511:504]); end
    total++;
    if (frame_data[15:8] !== 8'hFF) begin bad++; $display("FAIL neg_px01 got=%h want=ff", frame_data[15:8]); end
    total++;
    if (frame_data !== exp_img) begin bad++; $display("FAIL neg_tile got=%h want=%h", frame_data, exp_img); end
  endtask

  task automatic test_abort();
    apply_reset();
    for (int i = 0; i < 20; i++) push(8'h20 + 8'(i), i == 0);
    for (int i = 0; i < N*N - 1; i++) push(8'h40 + 8'(i), i == 0);
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL abort_early got=%b want=0", frame_valid); end
    push(8'h40 + 8'(N*N - 1), 1'b0);
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got=%b want=1", frame_valid); end
    total++;
    if (frame_data !== tile_img(8'h40)) begin bad++; $display("FAIL abort_tile got=%h want=%h", frame_data, tile_img(8'h40)); end
`ifdef FRAME_LOADER_STATS_EN
    total++;
    if (abort_cnt !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d want=1", abort_cnt); end
    total++;
    if (drop_cnt !== 16'd0) begin bad++; $display("FAIL abort_drop_cnt got=%0d want=0", drop_cnt); end
`endif
  endtask

  task automatic test_drop();
    pixel_t px;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      px = pixel_t'(8'hA0 + 8'(i));
      push(px, 1'b0);
    end
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b want=0", frame_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
    total++;
    if (frame_data !== '0) begin bad++; $display("FAIL drop_nowrite got=%h want=0", frame_data); end
`ifdef FRAME_LOADER_STATS_EN
    total++;
    if (drop_cnt !== 16'd5) begin bad++; $display("FAIL drop_cnt got=%0d want=5", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    stream_tile(8'h33);
    for (int i = 0; i < 30; i++) push(8'h70 + 8'(i), i == 0);
    total++;
    if (frame_valid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b/%b want=1/1", frame_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_valid got=%b want=0", frame_valid); end
    total++;
    if (busy !== 1'b0 || pix_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_async_ctl got=%b/%b want=0/0", busy, pix_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    stream_tile(8'h5A);
    total++;
    if (frame_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid got=%b want=1", frame_valid); end
    total++;
    if (frame_data !== tile_img(8'h5A)) begin bad++; $display("FAIL midrst_tile got=%h want=%h", frame_data, tile_img(8'h5A)); end
  endtask

  initial begin
    rst_n       = 1'b0;
    pix_valid   = 1'b0;
    pix_sof     = 1'b0;
    pix_data    = '0;
    frame_ready = 1'b0;
    test_reset();
    test_single_tile();
    test_back_to_back();
    test_negative();
    test_abort();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
